// File: rtl/boot_loader_if.sv
// boot_loader_if: valid/ready stream carrying the length-prefixed program.
// The master drives words and the slave (the loader) returns in_ready.
interface boot_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed program into instruction memory
// from address 0. The processor's fetch reset is held for the whole load and
// released RESET_HOLD cycles after the final write.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN. When it is defined, a
// trailing checksum word (the wrapping sum of the data words) must match
// before the processor is released.
module boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int RESET_HOLD = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  boot_loader_if.slave          s_in,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  // count is one bit wider than the address so a full-memory load never wraps
  localparam int          CW      = ADDR_WIDTH + 1;
  localparam int          HW      = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);
  localparam logic [31:0] MAX_LEN = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
`ifdef BOOT_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_len;
  logic [CW-1:0]         r_count;
  logic [HW-1:0]         r_hold;
  logic                  r_in_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;
`endif

  logic          w_xfer;
  logic          w_len_bad;
  logic [CW-1:0] w_count_inc;

  assign w_xfer      = s_in.in_valid & r_in_ready;
  assign w_len_bad   = (s_in.in_data == '0) || (32'(s_in.in_data) > MAX_LEN);
  assign w_count_inc = r_count + CW'(1);

  assign s_in.in_ready = r_in_ready;
  assign imem_we       = r_we;
  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;
  assign cpu_reset     = r_cpu_reset;
  assign done          = r_done;
  assign error         = r_error;

  // Load sequencer: state, handshake, memory write port and release timing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_hold      <= '0;
      r_in_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LEN;
            r_in_ready <= 1'b1;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            if (w_len_bad) begin
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_len   <= CW'(s_in.in_data);
              r_count <= '0;
              r_state <= S_LOAD;
`ifdef BOOT_LOADER_CHECKSUM_EN
              r_sum   <= '0;
`endif
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_we    <= 1'b1;
            r_addr  <= r_count[ADDR_WIDTH-1:0];
            r_wdata <= s_in.in_data;
            r_count <= w_count_inc;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_sum   <= r_sum + s_in.in_data;
            if (w_count_inc == r_len) begin
              r_state <= S_CSUM;
            end
`else
            if (w_count_inc == r_len) begin
              r_state    <= S_HOLD;
              r_in_ready <= 1'b0;
              r_hold     <= '0;
            end
`endif
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        // checksum word is compared only, never written to memory
        S_CSUM: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (s_in.in_data == r_sum) begin
              r_state <= S_HOLD;
              r_hold  <= '0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        S_HOLD: begin
          if (r_hold == HW'(RESET_HOLD)) begin
            r_state     <= S_RUN;
            r_cpu_reset <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_RUN: begin
          if (start) begin
            r_state     <= S_LEN;
            r_in_ready  <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_ERR: begin
          if (start) begin
            r_state    <= S_LEN;
            r_in_ready <= 1'b1;
            r_error    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table-driven loads plus hand-written corner sequences.
// Expected memory writes go into a scoreboard queue as words are accepted
// and are popped by a monitor whenever imem_we pulses.
module tb_boot_loader;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int RH = 2;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  boot_loader_if #(.DATA_WIDTH(DW)) bus ();

  boot_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_HOLD(RH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s_in      (bus),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [15:0]      hdr;
    int               nw;
    logic [3:0][15:0] w;
    bit               gap;
    bit               hdr_bad;
    bit               csum_bad;
  } vec_t;

  wr_t  sb_q[$];
  vec_t tbl[7];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", 32'(imem_wdata), 32'(e.data));
        $display("write addr %0h data %0h", imem_addr, imem_wdata);
      end
    end
  end

  // Offer one word until it is accepted; returns #1 after the accepting edge
  task automatic send_word(input logic [15:0] d, input bit push, input int addr);
    bit acc;
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 50; k++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no accept for word %0h expected accept within 50 cycles", d);
    end else if (push) begin
      sb_q.push_back('{addr: AW'(addr), data: d});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the final accepting edge: release must come 1+RH edges later
  task automatic check_release(input string tag);
    chk({tag, "_ready_drop"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_held0"}, 32'(cpu_reset), 32'd1);
    repeat (RH) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_held_last"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_released"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    $display("load %s released", tag);
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [15:0] sum;
    string       tag;
    v   = tbl[idx];
    tag = $sformatf("vec%0d", idx);
    sum = '0;
    pulse_start();
    send_word(v.hdr, 1'b0, 0);
    if (v.hdr_bad) begin
      chk({tag, "_error"}, 32'(error), 32'd1);
      chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      $display("load %s rejected length %0h", tag, v.hdr);
      return;
    end
    for (int i = 0; i < v.nw; i++) begin
      send_word(v.w[i], 1'b1, i);
      sum = sum + v.w[i];
      if (v.gap && i < v.nw - 1) begin
        // start during a load must be ignored
        start = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        start = 1'b0;
      end
    end
    if (CSUM_ON) begin
      send_word(v.csum_bad ? sum + 16'd1 : sum, 1'b0, 0);
      if (v.csum_bad) begin
        chk({tag, "_csum_error"}, 32'(error), 32'd1);
        chk({tag, "_csum_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_csum_ready"}, 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_csum_sb_empty"}, 32'(sb_q.size()), 32'd0);
        $display("load %s checksum rejected", tag);
        return;
      end
    end
    check_release(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0003, 3, {16'h0000, 16'h3333, 16'h2222, 16'h1111}, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 0, 64'h0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h0401, 0, 64'h0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h0001, 1, {16'h0000, 16'h0000, 16'h0000, 16'hABCD}, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h0002, 2, {16'h0000, 16'h0000, 16'h0B0B, 16'h0A0A}, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{16'h0002, 2, {16'h0000, 16'h0000, 16'h0002, 16'h0001}, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h0002, 2, {16'h0000, 16'h0000, 16'h0002, 16'h0001}, 1'b0, 1'b0, 1'b1};

    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Full-memory load: last address 2**AW-1, no wrap
    pulse_start();
    send_word(16'h0400, 1'b0, 0);
    for (int i = 0; i < 1024; i++) send_word(16'(i) ^ 16'h5000, 1'b1, i);
    if (CSUM_ON) begin
      logic [15:0] s;
      s = '0;
      for (int i = 0; i < 1024; i++) s = s + (16'(i) ^ 16'h5000);
      send_word(s, 1'b0, 0);
    end
    check_release("full");

    // Reset after one of four words, then start+in_valid together in IDLE
    pulse_start();
    send_word(16'h0004, 1'b0, 0);
    send_word(16'h7777, 1'b1, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_imem_we", 32'(imem_we), 32'd0);
    chk("mid_rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_imem_wdata", 32'(imem_wdata), 32'd0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    @(posedge clk);
    #1;
    chk("idle_no_ready", 32'(bus.in_ready), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("len_ready", 32'(bus.in_ready), 32'd1);
    send_word(16'h0001, 1'b0, 0);
    send_word(16'h5A5A, 1'b1, 0);
    if (CSUM_ON) send_word(16'h5A5A, 1'b0, 0);
    check_release("after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Program loader sitting directly upstream of the pipelined processor.
- Receives a length-prefixed stream of 16-bit instruction words on a valid/ready interface and writes them into instruction memory from address 0.
- Holds the processor's fetch reset asserted for the whole load. Releases it a fixed number of cycles after the last word is written, so fetch starts at address 0 with a fully loaded program.

Parameters:
- ADDR_WIDTH, 10, instruction memory address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, instruction word width.
- RESET_HOLD, 2, cycles cpu_reset stays high after the final memory write (minimum 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, RUN or ERR.
- in_valid  input  1  stream word present on in_data.
- in_data  input  DATA_WIDTH  stream word: the length first, then the instructions.
- in_ready  output  1  loader accepts in_data this cycle.
- imem_we  output  1  instruction memory write enable (registered).
- imem_addr  output  ADDR_WIDTH  instruction memory write address (registered).
- imem_wdata  output  DATA_WIDTH  instruction memory write data (registered).
- cpu_reset  output  1  drives the processor fetch reset; high means the processor is held.
- done  output  1  program loaded and processor released.
- error  output  1  load aborted.

Behaviour:
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - State = IDLE; internal length and count = 0.
- Handshake:
  - A word transfers on a cycle where in_valid & in_ready.
  - in_ready is high only in LEN, LOAD and CSUM, and is a registered function of state.
  - in_valid may drop at any time; gaps stall the load with no side effects.
- States:
  - IDLE: cpu_reset=1. start goes to LEN.
  - LEN: the first accepted word is the length N.
    - N==0 or N>2**ADDR_WIDTH: go to ERR.
    - Otherwise latch N, clear count, go to LOAD.
  - LOAD: each accepted word is written.
    - Cycle after acceptance: imem_we=1, imem_addr=count, imem_wdata=word; count increments.
    - On the Nth accepted word, in_ready drops the next cycle and the state goes to HOLD (or CSUM with the optional feature).
    - imem_we is high for exactly one cycle per accepted word.
  - HOLD: counts RESET_HOLD cycles starting the cycle after the final imem_we pulse, then goes to RUN.
  - RUN: cpu_reset=0, done=1.
    - start returns to LEN with cpu_reset=1 and done=0 on the next cycle (reload).
  - ERR: error=1, cpu_reset=1, done=0.
    - start goes to LEN and clears error on the next cycle.
- Address arithmetic:
  - count is ADDR_WIDTH+1 bits, so N = 2**ADDR_WIDTH loads the full memory with no wrap.
  - imem_addr takes the low ADDR_WIDTH bits of count; the last address written is 2**ADDR_WIDTH-1.
- start outside IDLE/RUN/ERR is ignored.
- reset in any state, including mid-LOAD, returns all outputs to their reset values on the next edge. A partially written program is not cleared, and cpu_reset stays 1 throughout.
- start and in_valid in the same cycle in IDLE: start is taken; in_ready is still 0, so no word transfers that cycle.
- Latency from the last word accepted to cpu_reset falling = 1 (write) + RESET_HOLD cycles.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - After the Nth word the state goes to CSUM, with in_ready=1.
  - The next accepted word is compared with the DATA_WIDTH-bit wrapping sum of the N data words.
  - Match goes to HOLD. Mismatch goes to ERR, and cpu_reset stays 1.
  - The checksum word is never written to memory.
- Undefined:
  - The CSUM state and sum register are absent; LOAD goes directly to HOLD.

Test Plan:
- Basic load: reset, start, then stream 0x0003, 0x1111, 0x2222, 0x3333 with in_valid held high.
  - Expect imem_we pulses at addr 0,1,2 with data 0x1111/0x2222/0x3333.
  - cpu_reset falls 1+RESET_HOLD=3 cycles after the last accept; done=1.
- Zero length: start then 0x0000 → next cycle error=1, cpu_reset=1, no imem_we.
- Oversize length: start then 0x0401 (ADDR_WIDTH=10) → error=1.
  - A second start followed by 0x0001, 0xABCD recovers: a write at addr 0, then done=1 and error=0.
- Stalled stream: N=2 with in_valid toggling 1,0,0,1.
  - Exactly two imem_we pulses at addr 0 and 1; in_ready drops after the second accept.
- Reset mid-load: assert reset after 1 of 4 words.
  - All outputs return to reset values; the state is IDLE.
  - A new start with N=1 writes to addr 0.
- Checksum (macro defined): 0x0002, 0x0001, 0x0002, 0x0003 → done=1.
  - The same stream with a final word of 0x0004 → error=1, cpu_reset=1, two writes only.
